// File: rtl/qubit_gate_sequencer_if.sv
// Bundle of the command, gate-strobe, measurement and status signals that
// connect a host and the qubit controller to the gate sequencer.
interface qubit_gate_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic            apply_X_gate;
    logic            apply_Hadamard_gate;
    logic [1:0]      qubit_state;
    logic            meas_valid;
    logic [1:0]      meas_data;
    logic            meas_ready;
    logic            busy;
    logic [CW-1:0]   fifo_count;
    logic [CNTW-1:0] ops_issued;

    // Host and qubit-controller side of the bundle.
    modport master (
        output cmd_valid, cmd_op, qubit_state, meas_ready,
        input  cmd_ready, apply_X_gate, apply_Hadamard_gate,
               meas_valid, meas_data, busy, fifo_count, ops_issued
    );

    // Sequencer side of the bundle.
    modport slave (
        input  cmd_valid, cmd_op, qubit_state, meas_ready,
        output cmd_ready, apply_X_gate, apply_Hadamard_gate,
               meas_valid, meas_data, busy, fifo_count, ops_issued
    );
endinterface

// File: rtl/qubit_gate_sequencer.sv
// Gate sequencer: buffers X/H/NOP/MEASURE opcodes in a FIFO, issues one-cycle
// gate strobes separated by a settle gap, and returns sampled qubit state
// over a valid/ready result channel.
module qubit_gate_sequencer #(
    parameter int DEPTH = 8,
    parameter int GAP   = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    qubit_gate_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_X    = 2'b01;
    localparam logic [1:0] OP_H    = 2'b10;
    localparam logic [1:0] OP_MEAS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_GAP     = 3'd2,
        ST_MSAMPLE = 3'd3,
        ST_MHOLD   = 3'd4
    } state_e;

    logic [1:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    state_e          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            x_q, x_d, h_q, h_d;
    logic            meas_valid_q, meas_valid_d;
    logic [1:0]      meas_data_q, meas_data_d;
    logic [CNTW-1:0] ops_q, ops_d;

    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic [1:0]      head_s;

    assign full_s = (count_q == CW'(DEPTH));
    assign push_s = bus.cmd_valid && !full_s;
    assign head_s = mem_q[rd_ptr_q];

    // Command FIFO storage, pointers and occupancy; the count only reflects a
    // push after the edge, so a fresh entry is poppable one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.cmd_op;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer state and registered outputs; async reset drops strobes at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= {GW{1'b0}};
            x_q          <= 1'b0;
            h_q          <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_data_q  <= 2'b00;
            ops_q        <= {CNTW{1'b0}};
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            x_q          <= x_d;
            h_q          <= h_d;
            meas_valid_q <= meas_valid_d;
            meas_data_q  <= meas_data_d;
            ops_q        <= ops_d;
        end
    end

    // Next-state logic: pop in IDLE, strobe during ISSUE, settle in GAP,
    // sample then hold a measurement until the consumer takes it.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        x_d          = 1'b0;
        h_d          = 1'b0;
        meas_valid_d = meas_valid_q;
        meas_data_d  = meas_data_q;
        ops_d        = ops_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != {CW{1'b0}}) begin
                    pop_s = 1'b1;
                    case (head_s)
                        OP_X: begin
                            state_d = ST_ISSUE;
                            x_d     = 1'b1;
                        end
                        OP_H: begin
                            state_d = ST_ISSUE;
                            h_d     = 1'b1;
                        end
                        OP_MEAS: state_d = ST_MSAMPLE;
                        OP_NOP:  state_d = ST_IDLE;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ops_d = ops_q + CNTW'(1);
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(GAP);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            ST_MSAMPLE: begin
                meas_data_d  = bus.qubit_state;
                meas_valid_d = 1'b1;
                state_d      = ST_MHOLD;
            end
            ST_MHOLD: begin
                if (bus.meas_ready) begin
                    meas_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_MHOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready           = !full_s;
    assign bus.apply_X_gate        = x_q;
    assign bus.apply_Hadamard_gate = h_q;
    assign bus.meas_valid          = meas_valid_q;
    assign bus.meas_data           = meas_data_q;
    assign bus.busy                = (state_q != ST_IDLE) || (count_q != {CW{1'b0}});
    assign bus.fifo_count          = count_q;
    assign bus.ops_issued          = ops_q;
endmodule

// File: tb/tb_qubit_gate_sequencer.sv
// Scoreboard bench for the gate sequencer with a small qubit-controller model
// (X inverts both state bits, H toggles bit 0).
module tb_qubit_gate_sequencer;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int CNTW  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [1:0] gate_q[$];
    logic [1:0] meas_q[$];
    int         strobe_cyc[$];
    logic [1:0] mstate = 2'b00;
    logic [1:0] qstate;

    qubit_gate_sequencer_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

    qubit_gate_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .CNTW(CNTW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign bus.qubit_state = qstate;

    always @(posedge clock or negedge reset) begin
        if (!reset)                      qstate <= 2'b00;
        else if (bus.apply_X_gate)       qstate <= ~qstate;
        else if (bus.apply_Hadamard_gate) qstate <= qstate ^ 2'b01;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (bus.apply_X_gate || bus.apply_Hadamard_gate) begin
                check_eq("one_strobe", 32'(bus.apply_X_gate & bus.apply_Hadamard_gate), 32'd0);
                strobe_cyc.push_back(cyc);
                if (gate_q.size() == 0)
                    check_eq("unexpected_strobe", 32'({bus.apply_Hadamard_gate, bus.apply_X_gate}), 32'd0);
                else
                    check_eq("gate_order", 32'({bus.apply_Hadamard_gate, bus.apply_X_gate}), 32'(gate_q.pop_front()));
            end
            if (bus.meas_valid && bus.meas_ready) begin
                if (meas_q.size() == 0)
                    check_eq("unexpected_meas", 32'd1, 32'd0);
                else
                    check_eq("meas_data", 32'(bus.meas_data), 32'(meas_q.pop_front()));
            end
        end
    end

    task automatic model_accept(input logic [1:0] op);
        case (op)
            2'b01: begin gate_q.push_back(2'b01); mstate = mstate ^ 2'b11; end
            2'b10: begin gate_q.push_back(2'b10); mstate = mstate ^ 2'b01; end
            2'b11: meas_q.push_back(mstate);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.meas_ready = 1'b1;
        gate_q.delete();
        meas_q.delete();
        mstate = 2'b00;
        @(negedge clock);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_strobes", 32'({bus.apply_X_gate, bus.apply_Hadamard_gate}), 32'd0);
        check_eq("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
        check_eq("rst_meas_data", 32'(bus.meas_data), 32'd0);
        check_eq("rst_ops", 32'(bus.ops_issued), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_count", 32'(bus.fifo_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        strobe_cyc.delete();
        @(posedge clock); #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, output int t);
        int n;
        n = 0;
        t = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        while (t < 0 && n < 200) begin
            @(negedge clock);
            if (bus.cmd_ready) t = cyc;
            @(posedge clock); #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (t < 0) check_eq("push_timeout", 32'd0, 32'd1);
        else model_accept(op);
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        t = -1;
        while (t < 0 && n < 500) begin
            @(negedge clock);
            if (!bus.busy) t = cyc;
            n++;
        end
        if (t < 0) check_eq("idle_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, ti, idx, n;
        logic [1:0] ops [10];
        bit acc;

        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.meas_ready = 1'b1;

        // Single X: latency, counter, busy drop after the gap.
        do_reset();
        push_cmd(2'b01, t0);
        wait_idle(ti);
        check_eq("x_strobe_count", 32'(strobe_cyc.size()), 32'd1);
        if (strobe_cyc.size() > 0) check_eq("x_strobe_cycle", 32'(strobe_cyc[0]), 32'(t0 + 2));
        check_eq("x_busy_drop_cycle", 32'(ti), 32'(t0 + 3 + GAP));
        check_eq("x_ops", 32'(bus.ops_issued), 32'd1);
        check_eq("x_busy", 32'(bus.busy), 32'd0);

        // X,H,X back-to-back: spacing GAP+2.
        do_reset();
        push_cmd(2'b01, t0);
        push_cmd(2'b10, t1);
        push_cmd(2'b01, t2);
        wait_idle(ti);
        check_eq("xhx_strobes", 32'(strobe_cyc.size()), 32'd3);
        if (strobe_cyc.size() == 3) begin
            check_eq("xhx_s0", 32'(strobe_cyc[0]), 32'(t0 + 2));
            check_eq("xhx_s1", 32'(strobe_cyc[1]), 32'(t0 + 6));
            check_eq("xhx_s2", 32'(strobe_cyc[2]), 32'(t0 + 10));
        end
        check_eq("xhx_ops", 32'(bus.ops_issued), 32'd3);

        // Fill while stalled in MHOLD, then drain in order.
        do_reset();
        bus.meas_ready = 1'b0;
        ops = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
        idx = 0;
        bus.cmd_valid = 1'b1;
        for (n = 0; n < 30; n++) begin
            bus.cmd_op = ops[idx];
            @(negedge clock);
            acc = bus.cmd_ready;
            @(posedge clock); #1;
            if (acc) begin
                model_accept(ops[idx]);
                if (idx < 9) idx++;
            end
        end
        @(negedge clock);
        check_eq("full_accepted", 32'(idx), 32'd9);
        check_eq("full_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("full_count", 32'(bus.fifo_count), 32'(DEPTH));
        check_eq("full_meas_valid", 32'(bus.meas_valid), 32'd1);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        bus.meas_ready = 1'b1;
        wait_idle(ti);
        check_eq("full_gates_left", 32'(gate_q.size()), 32'd0);
        check_eq("full_meas_left", 32'(meas_q.size()), 32'd0);
        check_eq("full_ops", 32'(bus.ops_issued), 32'd6);

        // X then MEASURE with a stalled consumer.
        do_reset();
        bus.meas_ready = 1'b0;
        push_cmd(2'b01, t0);
        push_cmd(2'b11, t1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.meas_valid && n < 100);
        check_eq("meas_appears", 32'(bus.meas_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_eq("meas_hold_valid", 32'(bus.meas_valid), 32'd1);
            check_eq("meas_hold_data", 32'(bus.meas_data), 32'd3);
        end
        @(posedge clock); #1;
        bus.meas_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("meas_cleared", 32'(bus.meas_valid), 32'd0);
        check_eq("meas_left", 32'(meas_q.size()), 32'd0);
        @(posedge clock); #1;

        // NOP,NOP,H: H strobe delayed by two cycles.
        do_reset();
        push_cmd(2'b00, t0);
        push_cmd(2'b00, t1);
        push_cmd(2'b10, t2);
        wait_idle(ti);
        check_eq("nop_strobes", 32'(strobe_cyc.size()), 32'd1);
        if (strobe_cyc.size() > 0) check_eq("nop_h_cycle", 32'(strobe_cyc[0]), 32'(t0 + 4));
        check_eq("nop_ops", 32'(bus.ops_issued), 32'd1);

        // Reset during ISSUE of H with an X still queued.
        do_reset();
        push_cmd(2'b10, t0);
        push_cmd(2'b01, t1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.apply_Hadamard_gate && n < 50);
        check_eq("h_seen", 32'(bus.apply_Hadamard_gate), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_h_drop", 32'(bus.apply_Hadamard_gate), 32'd0);
        check_eq("async_count", 32'(bus.fifo_count), 32'd0);
        gate_q.delete();
        meas_q.delete();
        mstate = 2'b00;
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check_eq("post_rst_count", 32'(bus.fifo_count), 32'd0);
        check_eq("post_rst_ops", 32'(bus.ops_issued), 32'd0);
        check_eq("post_rst_meas_valid", 32'(bus.meas_valid), 32'd0);
        check_eq("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
